// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// -----------
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock. Sits between the binary price/quantity datapath
// and the 7-segment display drivers.
//
// Handshake: start is a request that is taken only while busy=0. The edge
// that takes it raises busy; the edge that finishes the conversion lowers
// busy and raises done for exactly one cycle. done is not gated by any
// ready input, so the result must be captured in the done cycle or read
// from the held output registers later. A start seen while busy=1 is dropped.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-high reset
//   start      conversion request, sampled only while busy=0
//   bin        unsigned operand, captured on the accepting edge
//   busy       conversion in progress
//   done       one-cycle pulse: bcd/ovf/nz_digits were updated this cycle
//   bcd        result, digit 0 in [3:0]; held until the next done
//   ovf        value exceeded 10^DIGITS-1; bcd holds the low DIGITS digits
//   nz_digits  significant digit count (1 for a value of zero)
//
// An all-ones operand is the "invalid/blank" sentinel and is passed through
// as all-ones BCD after a single cycle.

module bin2bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [4*DIGITS-1:0]           bcd,
    output logic                          ovf,
    output logic [$clog2(DIGITS+1)-1:0]   nz_digits
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int NZW   = $clog2(DIGITS + 1);
    localparam int CW    = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SENT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   acc;
    logic               ovf_acc;
    logic [CW-1:0]      cnt;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_shift;
    logic               ovf_bit;
    logic [NZW-1:0]     nz_shift;
    logic               last_iter;

    assign busy      = (state != IDLE);
    assign last_iter = (cnt == CW'(1));

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (bin == '1) ? SENT : SHIFT;
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            SENT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble iteration. Every digit is corrected from its
    // pre-shift value; no carry crosses digit boundaries because a corrected
    // digit of at most 12 still fits in 4 bits. Only the bit shifted out of
    // the top digit is lost, and that is what raises overflow.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        ovf_bit   = acc_adj[BCD_W-1];
        acc_shift = {acc_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    end

    // Significant digits of the post-shift value: highest nonzero index + 1.
    always_comb begin
        nz_shift = NZW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_shift[4*i +: 4] != 4'd0) begin
                nz_shift = NZW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bin_sr    <= '0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
            done      <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            nz_digits <= NZW'(1);
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CW'(BIN_W);
                    end
                end
                SHIFT: begin
                    bin_sr  <= bin_sr << 1;
                    acc     <= acc_shift;
                    ovf_acc <= ovf_acc | ovf_bit;
                    cnt     <= cnt - CW'(1);
                    if (last_iter) begin
                        bcd       <= acc_shift;
                        ovf       <= ovf_acc | ovf_bit;
                        nz_digits <= nz_shift;
                        done      <= 1'b1;
                    end
                end
                SENT: begin
                    bcd       <= '1;
                    ovf       <= 1'b0;
                    nz_digits <= NZW'(DIGITS);
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;

    logic        start4;
    logic [11:0] bin4;
    logic        busy4;
    logic        done4;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [2:0]  nz4;

    logic        start3;
    logic [11:0] bin3;
    logic        busy3;
    logic        done3;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [1:0]  nz3;

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .bin       (bin4),
        .busy      (busy4),
        .done      (done4),
        .bcd       (bcd4),
        .ovf       (ovf4),
        .nz_digits (nz4)
    );

    bin2bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .bin       (bin3),
        .busy      (busy3),
        .done      (done3),
        .bcd       (bcd3),
        .ovf       (ovf3),
        .nz_digits (nz3)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the selected DUT, counting edges; bounded.
    task automatic wait_done(input bit use3, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if ((use3 ? done3 : done4) === 1'b1) return;
        end
        n = -1;
    endtask

    // Present start for one edge, then check latency and results.
    task automatic run(input bit use3, input string tag, input logic [11:0] v,
                       input logic [15:0] exp_bcd, input int exp_nz,
                       input bit exp_ovf, input int exp_lat);
        int n;
        @(negedge clk);
        if (use3) begin start3 = 1'b1; bin3 = v; end
        else      begin start4 = 1'b1; bin4 = v; end
        step();
        start3 = 1'b0;
        start4 = 1'b0;
        chk({tag, "_busy"}, use3 ? busy3 : busy4, 1'b1);
        wait_done(use3, n);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_bcd"}, use3 ? {4'h0, bcd3} : bcd4, exp_bcd);
        chk({tag, "_nz"}, use3 ? {1'b0, nz3} : nz4, exp_nz);
        chk({tag, "_ovf"}, use3 ? ovf3 : ovf4, exp_ovf);
        chk({tag, "_busy_done"}, use3 ? busy3 : busy4, 1'b0);
        step();
        chk({tag, "_done_pulse"}, use3 ? done3 : done4, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int dones;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start4 = 1'b0;
        bin4   = '0;
        start3 = 1'b0;
        bin3   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst_bcd", bcd4, 16'h0000);
        chk("rst_ovf", ovf4, 1'b0);
        chk("rst_nz", nz4, 3'd1);
        chk("rst_nz3", nz3, 2'd1);

        // 4-digit conversions
        run(1'b0, "zero", 12'd0,    16'h0000, 1, 1'b0, 12);
        run(1'b0, "d999", 12'd999,  16'h0999, 3, 1'b0, 12);
        run(1'b0, "d4094", 12'd4094, 16'h4094, 4, 1'b0, 12);
        run(1'b0, "d7",   12'd7,    16'h0007, 1, 1'b0, 12);
        run(1'b0, "d1000", 12'd1000, 16'h1000, 4, 1'b0, 12);
        run(1'b0, "sent", 12'hFFF,  16'hFFFF, 4, 1'b0, 1);

        // 3-digit conversions: overflow keeps the low digits
        run(1'b1, "ovf1234", 12'd1234, 16'h0234, 3, 1'b1, 12);
        run(1'b1, "d3_999",  12'd999,  16'h0999, 3, 1'b0, 12);
        run(1'b1, "d3_1000", 12'd1000, 16'h0000, 1, 1'b1, 12);
        run(1'b1, "d3_sent", 12'hFFF,  16'h0FFF, 3, 1'b0, 1);

        // Start while busy is ignored
        @(negedge clk);
        start4 = 1'b1;
        bin4   = 12'd321;
        step();
        start4 = 1'b0;
        n = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (n == 4) begin start4 = 1'b1; bin4 = 12'd777; end
            if (n == 5) begin start4 = 1'b0; end
            step();
            n++;
            if (done4 === 1'b1) break;
        end
        chk("busy_start_lat", n, 12);
        chk("busy_start_bcd", bcd4, 16'h0321);

        // Start in the done cycle is accepted on the next edge
        start4 = 1'b1;
        bin4   = 12'd777;
        step();
        start4 = 1'b0;
        chk("b2b_busy", busy4, 1'b1);
        wait_done(1'b0, n);
        chk("b2b_lat", n, 12);
        chk("b2b_bcd", bcd4, 16'h0777);
        chk("b2b_nz", nz4, 3'd3);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done4 === 1'b1) dones++;
        end
        chk("no_queued_done", dones, 0);

        // Reset mid-conversion
        @(negedge clk);
        start4 = 1'b1;
        bin4   = 12'd321;
        step();
        start4 = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        #2;
        chk("mid_rst_busy", busy4, 1'b0);
        chk("mid_rst_done", done4, 1'b0);
        chk("mid_rst_bcd", bcd4, 16'h0000);
        chk("mid_rst_nz", nz4, 3'd1);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done4 === 1'b1) dones++;
        end
        chk("mid_rst_no_done", dones, 0);
        run(1'b0, "after_rst", 12'd50, 16'h0050, 2, 1'b0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on the run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
